mod_exp_ctrl: RTL and testbench
===============================

# mod_exp_ctrl

Sequencer for Montgomery modular exponentiation: computes `result = msg^exponent mod modulus` by issuing a series of Montgomery products to one external Montgomery-product datapath. Operand order is left-to-right square-and-multiply. The block sits between the RSA top level and the product datapath, owns all operand muxing and intermediate registers, and exposes a simple start/done handshake upward.

## Interface
- BITLEN, 1024: operand and modulus width.
- EXPLEN, 1024: maximum exponent width.
- EBW, $clog2(EXPLEN+1): width of `exp_bits`.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when `ready`=1.
- ready  out  1  high only in IDLE.
- msg  in  BITLEN  base, < modulus.
- exponent  in  EXPLEN  exponent, LSB-aligned.
- exp_bits  in  EBW  number of exponent bits processed, MSB first from bit exp_bits-1; ≤ EXPLEN.
- modulus  in  BITLEN  odd modulus M.
- r_mod_m  in  BITLEN  R mod M, with R = 2^BITLEN.
- r2_mod_m  in  BITLEN  R² mod M.
- done  out  1  one-cycle pulse; `result` is valid on that cycle.
- result  out  BITLEN  held until the next accepted start.
- mp_start  out  1  one-cycle pulse that launches a product.
- mp_a, mp_b, mp_m  out  BITLEN  product operands; stable from `mp_start` until `mp_done`.
- mp_done  in  1  one-cycle pulse from the datapath wrapper; `mp_p` is valid on that cycle.
- mp_p  in  BITLEN  product A·B·R⁻¹ mod M, fully reduced.

## Operation
States and transitions:
- IDLE
  - `ready`=1.
  - On `start`, latch every input into internal registers (exponent into a shift/index register) and go to TO_MONT.
- TO_MONT: issue mp(msg, r2_mod_m) and store the product into `xbar`. Set `acc` = r_mod_m.
  - Go to SQ if `exp_bits`≠0, else FROM_MONT.
- SQ: issue mp(acc, acc) and store the product into `acc`.
  - Go to MUL if the current exponent bit is 1.
  - Otherwise decrement the index, then go to SQ if index≠0, else FROM_MONT.
- MUL: issue mp(acc, xbar) and store the product into `acc`. Decrement the index, then go as for SQ.
- FROM_MONT: issue mp(acc, 1) and store the product into `result`. Go to DONE.
- DONE: pulse `done` and return to IDLE.

Operand and handshake rules:
- Each operation state has two phases.
  - ISSUE: one cycle; `mp_start`=1 with operands driven.
  - WAIT: hold operands and wait for `mp_done`.
- The capture and the next-state decision happen on the `mp_done` cycle.
- `mp_m` = latched modulus at all times after accept.
- Number of products = 2 + exp_bits + popcount(exponent[exp_bits-1:0]).
- Leading zero exponent bits are legal; each costs one square of the Montgomery-form value 1.

Boundary and error behaviour:
- `start` while not ready is ignored, with no side effects.
- `mp_done` outside WAIT is ignored.
- Reset mid-operation:
  - Next cycle is IDLE, with `mp_start`=0, `done`=0, `ready`=1 and `result`=0.
  - A late `mp_done` after reset is ignored.
- exp_bits=0: `result` = 1 (2 products).
- Inputs may change after accept without effect.

Reset values:
- State = IDLE, `ready`=1.
- `done`=0, `mp_start`=0, `result`=0.
- `mp_a`/`mp_b`/`mp_m`=0, `acc`/`xbar`=0.

## Timing
- `mp_start` is asserted the cycle after `start` is accepted.
- Each later `mp_start` is asserted the cycle after the previous `mp_done`.
- `done` is asserted the cycle after the final `mp_done`.
- `ready` rises with the cycle after `done`, so back-to-back operation is possible.
- Total latency from accept to `done` = Σ(1 + Dₖ) + 1, where Dₖ is the number of cycles from `mp_start` to `mp_done` for product k.
- No combinational path from `mp_done` or `mp_p` to any output; all outputs are registered.

## Structure
- Shared package (rsa_pkg) holds:
  - state encoding (IDLE, TO_MONT, SQ, MUL, FROM_MONT, DONE);
  - phase encoding (ISSUE, WAIT);
  - BITLEN/EXPLEN defaults.
- The product datapath stays outside this block.
  - Its wrapper converts the datapath completion into the `mp_done` pulse and guarantees a fully reduced `mp_p`.
- No sub-module is needed. The exponent index and bit select live inline.

## Test plan
Bench uses BITLEN=8, a behavioural product model with configurable delay D, M=13, r_mod_m=9, r2_mod_m=3.

1. msg=4, exponent=5, exp_bits=3, D=4 -> 7 `mp_start` pulses in order TO_MONT,SQ,MUL,SQ,SQ,MUL,FROM_MONT; `result`=10; `done` after 7·5+1=36 cycles.
2. msg=7, exp_bits=0 -> 2 products, `result`=1.
3. msg=2, exponent=255, exp_bits=8 -> 18 products, `result`=8. Rerun with D=1 and with D random 1–20: same result, and operands stable throughout WAIT.
4. `start` held high during operation -> only one accept, `ready`=0 until after `done`. A second start on the cycle after `done` is accepted.
5. Reset asserted after the 3rd `mp_start`, stray `mp_done` injected next cycle -> IDLE, `ready`=1, no `done`, no `mp_start`. A following clean run of scenario 1 gives `result`=10.
6. Inputs changed every cycle after accept (scenario 1 values) -> `result` still 10.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared state/phase encodings and width defaults for the RSA exponentiation blocks.
package rsa_pkg;

   localparam int DEFAULT_BITLEN = 1024;
   localparam int DEFAULT_EXPLEN = 1024;

   typedef enum logic [2:0] {
      IDLE,
      TO_MONT,
      SQ,
      MUL,
      FROM_MONT,
      DONE
   } state_t;

   typedef enum logic {
      ISSUE,
      WAIT
   } phase_t;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one external Montgomery-product datapath.
module mod_exp_ctrl
   import rsa_pkg::*;
#(
   parameter int BITLEN = DEFAULT_BITLEN,
   parameter int EXPLEN = DEFAULT_EXPLEN,
   parameter int EBW    = $clog2(EXPLEN + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              ready,
   input  logic [BITLEN-1:0] msg,
   input  logic [EXPLEN-1:0] exponent,
   input  logic [EBW-1:0]    exp_bits,
   input  logic [BITLEN-1:0] modulus,
   input  logic [BITLEN-1:0] r_mod_m,
   input  logic [BITLEN-1:0] r2_mod_m,
   output logic              done,
   output logic [BITLEN-1:0] result,
   output logic              mp_start,
   output logic [BITLEN-1:0] mp_a,
   output logic [BITLEN-1:0] mp_b,
   output logic [BITLEN-1:0] mp_m,
   input  logic              mp_done,
   input  logic [BITLEN-1:0] mp_p
);

   localparam logic [BITLEN-1:0] ONE = BITLEN'(1);

   state_t              state_q, state_d;
   phase_t              phase_q, phase_d;
   logic [EXPLEN-1:0]   exp_q, exp_d;
   logic [EBW-1:0]      idx_q, idx_d, idx_dec;
   logic [BITLEN-1:0]   acc_q, acc_d;
   logic [BITLEN-1:0]   xbar_q, xbar_d;
   logic [BITLEN-1:0]   result_d, mp_a_d, mp_b_d, mp_m_d;
   logic                mp_start_d, done_d, ready_d;
   logic                launch, advance;
   state_t              launch_state;
   logic [BITLEN-1:0]   launch_a, launch_b;

   // The exponent is stored MSB-aligned so the bit under test is always exp_q[EXPLEN-1].
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      exp_d        = exp_q;
      idx_d        = idx_q;
      acc_d        = acc_q;
      xbar_d       = xbar_q;
      result_d     = result;
      mp_a_d       = mp_a;
      mp_b_d       = mp_b;
      mp_m_d       = mp_m;
      mp_start_d   = 1'b0;
      done_d       = 1'b0;
      launch       = 1'b0;
      advance      = 1'b0;
      launch_state = state_q;
      launch_a     = mp_a;
      launch_b     = mp_b;
      idx_dec      = idx_q - EBW'(1);

      case (state_q)
         IDLE: begin
            if (start) begin
               exp_d        = exponent << (EBW'(EXPLEN) - exp_bits);
               idx_d        = exp_bits;
               acc_d        = r_mod_m;
               xbar_d       = '0;
               mp_m_d       = modulus;
               launch       = 1'b1;
               launch_state = TO_MONT;
               launch_a     = msg;
               launch_b     = r2_mod_m;
            end
         end
         TO_MONT, SQ, MUL, FROM_MONT: begin
            if (phase_q == ISSUE) begin
               phase_d = WAIT;
            end else if (mp_done) begin
               case (state_q)
                  TO_MONT: begin
                     xbar_d = mp_p;
                     launch = 1'b1;
                     if (idx_q != '0) begin
                        launch_state = SQ;
                        launch_a     = acc_q;
                        launch_b     = acc_q;
                     end else begin
                        launch_state = FROM_MONT;
                        launch_a     = acc_q;
                        launch_b     = ONE;
                     end
                  end
                  SQ: begin
                     acc_d = mp_p;
                     if (exp_q[EXPLEN-1]) begin
                        launch       = 1'b1;
                        launch_state = MUL;
                        launch_a     = mp_p;
                        launch_b     = xbar_q;
                     end else begin
                        advance = 1'b1;
                     end
                  end
                  MUL: begin
                     acc_d   = mp_p;
                     advance = 1'b1;
                  end
                  FROM_MONT: begin
                     result_d = mp_p;
                     state_d  = DONE;
                     phase_d  = ISSUE;
                     done_d   = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         DONE: begin
            state_d = IDLE;
            phase_d = ISSUE;
         end
         default: begin
            state_d = IDLE;
            phase_d = ISSUE;
         end
      endcase

      // The freshly captured product feeds the next operation directly from mp_p.
      if (advance) begin
         idx_d  = idx_dec;
         exp_d  = exp_q << 1;
         launch = 1'b1;
         if (idx_dec != '0) begin
            launch_state = SQ;
            launch_a     = mp_p;
            launch_b     = mp_p;
         end else begin
            launch_state = FROM_MONT;
            launch_a     = mp_p;
            launch_b     = ONE;
         end
      end

      if (launch) begin
         state_d    = launch_state;
         phase_d    = ISSUE;
         mp_start_d = 1'b1;
         mp_a_d     = launch_a;
         mp_b_d     = launch_b;
      end

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         phase_q  <= ISSUE;
         exp_q    <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         xbar_q   <= '0;
         result   <= '0;
         mp_a     <= '0;
         mp_b     <= '0;
         mp_m     <= '0;
         mp_start <= 1'b0;
         done     <= 1'b0;
         ready    <= 1'b1;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         exp_q    <= exp_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         xbar_q   <= xbar_d;
         result   <= result_d;
         mp_a     <= mp_a_d;
         mp_b     <= mp_b_d;
         mp_m     <= mp_m_d;
         mp_start <= mp_start_d;
         done     <= done_d;
         ready    <= ready_d;
      end
   end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with an 8-bit behavioural Montgomery product (M=13, R=256).
module tb_mod_exp_ctrl;

   localparam int BITLEN = 8;
   localparam int EXPLEN = 8;
   localparam int EBW    = 4;
   localparam logic [7:0] MODV  = 8'd13;
   localparam logic [7:0] RMODV = 8'd9;
   localparam logic [7:0] R2V   = 8'd3;
   localparam int RINV = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] msg = '0;
   logic [7:0] exponent = '0;
   logic [3:0] exp_bits = '0;
   logic [7:0] modulus = '0;
   logic [7:0] r_mod_m = '0;
   logic [7:0] r2_mod_m = '0;
   logic       mp_done = 1'b0;
   logic [7:0] mp_p = '0;
   logic       ready, done, mp_start;
   logic [7:0] result, mp_a, mp_b, mp_m;

   mod_exp_ctrl #(.BITLEN(BITLEN), .EXPLEN(EXPLEN), .EBW(EBW)) dut (
      .clk(clk), .reset(reset), .start(start), .ready(ready),
      .msg(msg), .exponent(exponent), .exp_bits(exp_bits),
      .modulus(modulus), .r_mod_m(r_mod_m), .r2_mod_m(r2_mod_m),
      .done(done), .result(result),
      .mp_start(mp_start), .mp_a(mp_a), .mp_b(mp_b), .mp_m(mp_m),
      .mp_done(mp_done), .mp_p(mp_p)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] res;
      int         nprod;
      int         lat;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] m;
   } op_t;

   exp_t exp_q[$];
   op_t  op_q[$];

   int check_cnt = 0;
   int pass_cnt = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int acc_cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int prod_cnt = 0;
   logic prev_ready = 1'b0;

   int d_fixed = 4;
   bit d_random = 1'b0;
   bit stray_req = 1'b0;
   bit scramble = 1'b0;

   // Scenario 1 operand pairs worked by hand: p = a*b*3 mod 13.
   logic [7:0] s1a [7] = '{8'd4, 8'd9, 8'd9,  8'd10, 8'd1, 8'd3,  8'd12};
   logic [7:0] s1b [7] = '{8'd3, 8'd9, 8'd10, 8'd10, 8'd1, 8'd10, 8'd1};

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      check_cnt++;
      if (actual == expected) pass_cnt++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   function automatic int pickDelay();
      if (d_random) return int'($urandom_range(1, 20));
      return d_fixed;
   endfunction

   // Behavioural product datapath: answers D cycles after each mp_start and watches operand stability.
   initial begin
      int cnt;
      logic [7:0] la, lb, lm;
      bit stable;
      cnt = 0;
      la = '0; lb = '0; lm = '0;
      stable = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         mp_done = 1'b0;
         if (reset) begin
            cnt = 0;
         end else if (cnt > 0) begin
            if (mp_a !== la || mp_b !== lb || mp_m !== lm) stable = 1'b0;
            cnt--;
            if (cnt == 0) begin
               mp_done = 1'b1;
               mp_p = 8'((int'(la) * int'(lb) * RINV) % int'(lm));
               checkOutput("operands_stable", longint'(stable), 1);
            end
         end
         if (mp_start) begin
            la = mp_a;
            lb = mp_b;
            lm = mp_m;
            stable = 1'b1;
            cnt = pickDelay();
         end
         if (stray_req) begin
            mp_done = 1'b1;
            mp_p = 8'h5A;
            stray_req = 1'b0;
         end
      end
   end

   // Monitor: tracks accepts/products and pops the scoreboard on every done pulse.
   initial begin
      exp_t e;
      op_t o;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (prev_ready && !ready) begin
            acc_cnt++;
            acc_cyc = cyc;
            prod_cnt = 0;
         end
         prev_ready = ready;
         if (mp_start) begin
            prod_cnt++;
            if (op_q.size() > 0) begin
               o = op_q.pop_front();
               checkOutput("mp_a", mp_a, o.a);
               checkOutput("mp_b", mp_b, o.b);
               checkOutput("mp_m", mp_m, o.m);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            checkOutput("ready_low_in_done", ready, 0);
            checkOutput("scoreboard_has_entry", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("result", result, e.res);
               checkOutput("product_count", prod_cnt, e.nprod);
               if (e.lat > 0) checkOutput("latency", cyc - acc_cyc + 1, e.lat);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic driveInputs(input logic [7:0] m, input logic [7:0] e, input logic [3:0] bits);
      msg = m;
      exponent = e;
      exp_bits = bits;
      modulus = MODV;
      r_mod_m = RMODV;
      r2_mod_m = R2V;
   endtask

   task automatic pushExpect(input logic [7:0] res, input int nprod, input int lat);
      exp_t e;
      e.res = res;
      e.nprod = nprod;
      e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic pushScen1Ops();
      op_t o;
      for (int i = 0; i < 7; i++) begin
         o.a = s1a[i];
         o.b = s1b[i];
         o.m = MODV;
         op_q.push_back(o);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] m, input logic [7:0] e, input logic [3:0] bits,
                                input logic [7:0] res, input int nprod, input int lat,
                                input bit expect_done);
      @(negedge clk);
      driveInputs(m, e, bits);
      start = 1'b1;
      if (expect_done) pushExpect(res, nprod, lat);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int base;
      int n;
      base = done_cnt;
      n = 0;
      while (done_cnt == base && n < budget) begin
         @(negedge clk);
         n++;
         if (scramble) begin
            msg = 8'($urandom);
            exponent = 8'($urandom);
            exp_bits = 4'($urandom_range(0, 8));
            modulus = 8'($urandom);
            r_mod_m = 8'($urandom);
            r2_mod_m = 8'($urandom);
         end
      end
      if (done_cnt == base) checkOutput("done_timeout", done_cnt - base, 1);
   endtask

   initial begin
      int a0;
      int d0;
      int n;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", ready, 1);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_mp_start", mp_start, 0);
      checkOutput("reset_result", result, 0);
      checkOutput("reset_mp_a", mp_a, 0);
      checkOutput("reset_mp_b", mp_b, 0);
      checkOutput("reset_mp_m", mp_m, 0);
      reset = 1'b0;

      // 4^5 mod 13, fixed delay 4
      d_fixed = 4;
      pushScen1Ops();
      applyStimulus(8'd4, 8'd5, 4'd3, 8'd10, 7, 36, 1'b1);
      waitDone(200);

      // exp_bits = 0 ignores the exponent value
      applyStimulus(8'd7, 8'hFF, 4'd0, 8'd1, 2, 11, 1'b1);
      waitDone(200);

      // 2^255 mod 13 under fixed 4, fixed 1 and random delays
      applyStimulus(8'd2, 8'd255, 4'd8, 8'd8, 18, 91, 1'b1);
      waitDone(500);
      d_fixed = 1;
      applyStimulus(8'd2, 8'd255, 4'd8, 8'd8, 18, 37, 1'b1);
      waitDone(500);
      d_random = 1'b1;
      applyStimulus(8'd2, 8'd255, 4'd8, 8'd8, 18, -1, 1'b1);
      waitDone(1000);
      d_random = 1'b0;
      d_fixed = 4;

      // start held high: one accept per run, next accept right after done
      @(negedge clk);
      driveInputs(8'd4, 8'd5, 4'd3);
      pushExpect(8'd10, 7, 36);
      pushExpect(8'd10, 7, 36);
      a0 = acc_cnt;
      start = 1'b1;
      waitDone(200);
      checkOutput("single_accept", acc_cnt - a0, 1);
      n = 0;
      while (acc_cnt - a0 < 2 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("second_accept", acc_cnt - a0, 2);
      checkOutput("b2b_accept_gap", acc_cyc - done_cyc, 2);
      start = 1'b0;
      waitDone(200);

      // reset after the third product launch, then a stray mp_done
      applyStimulus(8'd4, 8'd5, 4'd3, 8'd0, 0, 0, 1'b0);
      n = 0;
      while (prod_cnt < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("third_mp_start_seen", prod_cnt, 3);
      d0 = done_cnt;
      reset = 1'b1;
      stray_req = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort_ready", ready, 1);
      checkOutput("abort_mp_start", mp_start, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_result", result, 0);
      @(negedge clk);
      checkOutput("stray_ready", ready, 1);
      checkOutput("stray_mp_start", mp_start, 0);
      repeat (10) @(negedge clk);
      checkOutput("no_done_after_reset", done_cnt - d0, 0);
      checkOutput("no_launch_after_reset", prod_cnt, 3);
      pushScen1Ops();
      applyStimulus(8'd4, 8'd5, 4'd3, 8'd10, 7, 36, 1'b1);
      waitDone(200);

      // inputs scrambled every cycle after accept
      pushScen1Ops();
      applyStimulus(8'd4, 8'd5, 4'd3, 8'd10, 7, 36, 1'b1);
      scramble = 1'b1;
      waitDone(200);
      scramble = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", exp_q.size(), 0);
      checkOutput("operand_queue_drained", op_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
